// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: a shift-add multiplier and a restoring
// divider share one {hi, lo} accumulator. Finishes in WIDTH+1 cycles; divide-by-zero takes one.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [2:0]       op_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    // Operand decode at accept time
    logic             a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && a[WIDTH-1];
        b_neg    = b_signed && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        // Remainder follows the dividend; everything else follows the product/quotient sign.
        neg_in   = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

    // One datapath step of either algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH-1:0] mulh_neg, fin_value;

    always_comb begin
        mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        div_diff = {hi_reg, lo_reg[WIDTH-1]} - {1'b0, opnd_reg};
        div_ok   = !div_diff[WIDTH];
        if (op_reg[2]) begin
            hi_next = div_ok ? div_diff[WIDTH-1:0] : {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
            lo_next = {lo_reg[WIDTH-2:0], div_ok};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end

        // High half of -{hi, lo}: the carry into hi exists only when lo is zero.
        mulh_neg = ~hi_next + {{(WIDTH-1){1'b0}}, (lo_next == '0)};

        case (op_reg)
            OP_MUL:                       fin_value = lo_next;
            OP_MULH, OP_MULHSU, OP_MULHU: fin_value = neg_reg ? mulh_neg : hi_next;
            OP_DIV, OP_DIVU:              fin_value = neg_reg ? -lo_next : lo_next;
            default:                      fin_value = neg_reg ? -hi_next : hi_next;
        endcase
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            op_reg   <= OP_MUL;
            neg_reg  <= 1'b0;
            opnd_reg <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        if (op[2] && (b == '0)) begin
                            result <= op[1] ? a : '1;
                            done   <= 1'b1;
                        end else begin
                            op_reg   <= op;
                            neg_reg  <= neg_in;
                            // Divide keeps the divisor beside the accumulator, multiply the multiplicand.
                            opnd_reg <= op[2] ? b_mag : a_mag;
                            hi_reg   <= '0;
                            lo_reg   <= op[2] ? a_mag : b_mag;
                            count    <= CW'(WIDTH);
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        hi_reg <= hi_next;
                        lo_reg <= lo_next;
                        count  <= count - CW'(1);
                        if (count == CW'(1)) begin
                            result <= fin_value;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: WIDTH=32 and WIDTH=8 instances, with expected
// results from an integer reference model, checked when done pulses.
module tb_muldiv_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, kill32, ready32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, result32;
    logic        start8, kill8, ready8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp32_q[$];
    logic [31:0] exp8_q[$];
    logic [31:0] last32;

    muldiv_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .kill(kill32), .ready(ready32), .done(done32), .result(result32)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .kill(kill8), .ready(ready8), .done(done8), .result(result8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      ua, ub, sa, sb, q;
        logic [63:0] p;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = longint'({32'b0, a & mask});
        ub = longint'({32'b0, b & mask});
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        q = 0;
        p = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0] & mask; end
            3'd1: begin p = sa * sb; p = p >> w; return p[31:0] & mask; end
            3'd2: begin p = sa * ub; p = p >> w; return p[31:0] & mask; end
            3'd3: begin p = ua * ub; p = p >> w; return p[31:0] & mask; end
            3'd4: begin if (ub == 0) return mask; q = sa / sb; end
            3'd5: begin if (ub == 0) return mask; q = ua / ub; end
            3'd6: begin if (ub == 0) return a & mask; q = sa % sb; end
            default: begin if (ub == 0) return a & mask; q = ua % ub; end
        endcase
        p = q;
        return p[31:0] & mask;
    endfunction

    always @(negedge clk) begin
        if (reset && done32) begin
            if (exp32_q.size() == 0) check("done32_unexpected", 32'd1, 32'd0);
            else check("result32", result32, exp32_q.pop_front());
        end
        if (reset && done8) begin
            if (exp8_q.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
            else check("result8", {24'b0, result8}, exp8_q.pop_front());
        end
    end

    task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int low_cycles);
        int n;
        int lowc;
        logic [31:0] e;
        @(negedge clk);
        n = 0;
        while (!ready32 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_ready_before"}, {31'b0, ready32}, 32'd1);
        e = ref_model(32, op, a, b);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        exp32_q.push_back(e);
        $display("w32 %s op=%0d a=%h b=%h expect=%h", tag, op, a, b, e);
        @(posedge clk);
        #1 start32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
        n = 0; lowc = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (!ready32) lowc++;
            if (done32) break;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_ready_low"}, lowc, low_cycles);
        last32 = e;
    endtask

    task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        int n;
        logic [31:0] e;
        @(negedge clk);
        n = 0;
        while (!ready8 && n < 200) begin @(negedge clk); n++; end
        e = ref_model(8, op, {24'b0, a}, {24'b0, b});
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        exp8_q.push_back(e);
        $display("w8 %s op=%0d a=%h b=%h expect=%h", tag, op, a, b, e);
        @(posedge clk);
        #1 start8 = 1'b0;
        n = 0;
        while (n < 100) begin @(negedge clk); n++; if (done8) break; end
        check({tag, "_latency"}, n, 9);
    endtask

    initial begin
        int n;
        int saw_done;
        logic [31:0] e1, e2;
        reset = 1'b0; last32 = '0;
        start32 = 0; kill32 = 0; op32 = 0; a32 = 0; b32 = 0;
        start8 = 0; kill8 = 0; op8 = 0; a8 = 0; b8 = 0;
        #12;
        check("reset_ready", {31'b0, ready32}, 32'd1);
        check("reset_done", {31'b0, done32}, 32'd0);
        check("reset_result", result32, 32'd0);
        check("reset_ready8", {31'b0, ready8}, 32'd1);
        @(negedge clk) reset = 1'b1;

        run32("mul_7_m7",   3'd0, 32'd7,          32'hFFFF_FFF9, 33, 32);
        run32("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 33, 32);
        run32("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32);
        run32("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,         33, 32);
        run32("mulh_mixed", 3'd1, 32'hFFFF_FF00,  32'h0001_2345, 33, 32);
        run32("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         33, 32);
        run32("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         33, 32);
        run32("divu_100_7", 3'd5, 32'd100,        32'd7,         33, 32);
        run32("remu_100_7", 3'd7, 32'd100,        32'd7,         33, 32);
        run32("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32);
        run32("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32);
        run32("rem_m_negb", 3'd6, 32'd17,         32'hFFFF_FFFB, 33, 32);
        run32("divu_by0",   3'd5, 32'h0000_1234,  32'd0,         1, 0);
        run32("rem_by0",    3'd6, 32'hFFFF_FFFB,  32'd0,         1, 0);
        for (int i = 0; i < 6; i++)
            run32("rand", 3'($urandom), $urandom, $urandom | 32'd1, 33, 32);

        // kill mid-operation: no push, nothing may complete
        @(negedge clk);
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd1234; b32 = 32'd5678;
        $display("w32 kill op=0 a=%h b=%h expect=no_done", a32, b32);
        @(posedge clk); #1 start32 = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        @(negedge clk) kill32 = 1'b1;
        @(posedge clk); #1 kill32 = 1'b0;
        @(negedge clk);
        check("kill_ready", {31'b0, ready32}, 32'd1);
        check("kill_result_held", result32, last32);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done32) saw_done++; end
        check("kill_no_done", saw_done, 0);

        // asynchronous reset mid-operation
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd99; b32 = 32'd3;
        $display("w32 reset_mid op=0 a=%h b=%h expect=no_done", a32, b32);
        @(posedge clk); #1 start32 = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ready", {31'b0, ready32}, 32'd1);
        check("rst_mid_done", {31'b0, done32}, 32'd0);
        check("rst_mid_result", result32, 32'd0);
        @(negedge clk) reset = 1'b1;

        run8("mulhu_ff", 3'd3, 8'hFF, 8'hFF);
        run8("div8_ovf", 3'd4, 8'h80, 8'hFF);

        // back-to-back on WIDTH=8: second start issued during the done cycle
        @(negedge clk);
        e1 = ref_model(8, 3'd5, 32'd200, 32'd3);
        e2 = ref_model(8, 3'd7, 32'd200, 32'd3);
        start8 = 1'b1; op8 = 3'd5; a8 = 8'd200; b8 = 8'd3;
        exp8_q.push_back(e1);
        $display("w8 b2b_divu op=5 a=c8 b=03 expect=%h", e1);
        @(posedge clk); #1 start8 = 1'b0;
        n = 0;
        while (n < 100) begin @(negedge clk); n++; if (done8) break; end
        check("b2b_first_latency", n, 9);
        start8 = 1'b1; op8 = 3'd7; a8 = 8'd200; b8 = 8'd3;
        exp8_q.push_back(e2);
        $display("w8 b2b_remu op=7 a=c8 b=03 expect=%h", e2);
        @(posedge clk); #1 start8 = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (n == 1) check("b2b_result_held", {24'b0, result8}, e1);
            if (done8) break;
        end
        check("b2b_spacing", n, 9);

        repeat (5) @(negedge clk);
        check("q32_empty", exp32_q.size(), 0);
        check("q8_empty", exp8_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative, parametrised RV32M multiply/divide unit for the multicycle and pipelined XRISC cores. It replaces the combinational `*` and `/` paths in the ALU with a shift-add multiplier and a restoring divider that share one 2·WIDTH accumulator. It completes all eight M-extension operations in WIDTH+1 cycles, and divide-by-zero in 1 cycle. It sits beside the ALU, and the core stalls on `ready`.

## Interface
- WIDTH, 32, operand/result width (≥4, even); counter width is $clog2(WIDTH+1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  request; accepted only on an edge where `ready`=1
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  WIDTH  rs1 operand (dividend / multiplicand), sampled at accept
- b  in  WIDTH  rs2 operand (divisor / multiplier), sampled at accept
- kill  in  1  abort the in-flight operation (pipeline flush)
- ready  out  1  unit idle; can accept `start`
- done  out  1  one-cycle pulse; `result` is valid from this cycle
- result  out  WIDTH  registered result; held until the next completion

## Operation
- **States**
  - IDLE: `ready`=1.
  - CALC: `ready`=0; down-counter runs WIDTH→1.
  - Only one more state is needed if used. The completion write and the return to IDLE happen on the same edge, so `done` is asserted while in IDLE.
- **Accept (IDLE, start=1, kill=0)**
  - Latch `op`.
  - Latch the magnitudes |a| and |b|. A signed operand is negated only if its MSB is set and the op treats it as signed:
    - a signed for MULH, MULHSU, DIV, REM.
    - b signed for MULH, DIV, REM.
    - MUL is computed unsigned; its low half is sign-agnostic.
  - Latch the result sign flags.
  - Load count=WIDTH and go to CALC.
- **Divide-by-zero fast path**: if the op is a division and b==0, stay in IDLE and write the result at the next edge, with `done`=1:
  - DIV/DIVU → all ones.
  - REM/REMU → a (unmodified).
- **Multiply (CALC)**: one shift-add step per cycle on the {hi, lo} accumulator.
  - lo is initialised to |b|.
  - Each step adds |a| to hi if lo[0]=1, then shifts the WIDTH+1-bit sum right into {hi, lo}.
- **Divide (CALC)**: restoring division, one quotient bit per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract |b| from rem using WIDTH+1 bits.
  - If the difference is non-negative, keep it and set quo[0]=1.
- **Completion (count==1 edge)**: write `result`, assert `done`, return to IDLE.
  - MUL: low WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the 2·WIDTH product, negated as a 2·WIDTH value when the product sign is negative.
  - DIV/DIVU: quotient, negated if the operand signs differ (signed ops only).
  - REM/REMU: remainder, carrying the dividend's sign (signed ops only).
- **Overflow (DIV of most-negative by −1)** falls out of the datapath: quotient = 0x8000_0000 (WIDTH=32), remainder = 0. No special case is needed.
- **kill**
  - In CALC: next state is IDLE, no `done`, `result` unchanged.
  - In IDLE with `start`: the start is ignored.
  - Takes priority over completion on the same edge.
- **start while `ready`=0**: ignored, with no side effects.

## Timing
- Reset (reset=0): state=IDLE, count=0, `ready`=1, `done`=0, `result`=0, and the accumulator is cleared.
- **Latency** (start accepted at edge E0):
  - Normal operation: `done`=1 in the cycle following edge E0+WIDTH, with `ready`=0 for WIDTH cycles.
  - Divide-by-zero: `done`=1 in the cycle after E0, and `ready` never drops.
- **Back-to-back**: `start` may be asserted in the `done` cycle. It is accepted there, and that cycle's `result` stays valid until the next completion.
- `done` is never high for two consecutive cycles, except for consecutive divide-by-zero fast paths.
- Reset asserted mid-CALC: immediate return to the reset values; no `done` is produced.
- `a`, `b` and `op` may change freely after the accept edge.

## Test plan
- WIDTH=32, MUL a=7, b=0xFFFFFFF9 (−7) → `result`=0xFFFFFFCF, `done` in cycle 33 after `start`, `ready`=0 in cycles 1–32.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- DIVU 0x1234/0 → 0xFFFFFFFF and REM −5/0 → 0xFFFFFFFB, each with `done` one cycle after `start` and `ready` held high.
- MUL started, then `kill` at cycle 10 → no `done`, `ready`=1 at cycle 11, `result` keeps its prior value. Second run: reset=0 at cycle 5 → `ready`=1, `done`=0, `result`=0 immediately.
- WIDTH=8, MULHU 0xFF×0xFF → 0xFE in 9 cycles. Back-to-back DIVU 200/3 with start asserted in the `done` cycle → 66, then REMU 200/3 → 2, 9 cycles apart.
